spi_txn_scheduler: RTL

- Arbitrates SPI transactions from NUM_REQ requesters (button/switch front-end, config loaders, test hooks) onto the single SPI master engine.
- Issues one 32-bit frame at a time: 16-bit command followed by 16-bit data.
- Expands a global write into one frame per slave ID, 0..NUM_SLAVES-1, in sequence.
- Returns one response per accepted request, with a timeout on a stuck engine.

---
 rtl/spi_txn_scheduler.sv | 197 +++++++++++++++++++
 1 files changed

// File: rtl/spi_txn_scheduler.sv
// Round-robin arbiter that serialises requester transactions onto one SPI master
// engine, expanding global writes into one frame per slave and timing out stuck frames.
module spi_txn_scheduler #(
  parameter int unsigned NUM_REQ        = 4,
  parameter int unsigned NUM_SLAVES     = 8,
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_REQ-1:0]    req_valid,
  output logic [NUM_REQ-1:0]    req_ready,
  input  logic [NUM_REQ-1:0]    req_rw,
  input  logic [NUM_REQ-1:0]    req_global,
  input  logic [3*NUM_REQ-1:0]  req_id,
  input  logic [8*NUM_REQ-1:0]  req_addr,
  input  logic [16*NUM_REQ-1:0] req_wdata,
  output logic [NUM_REQ-1:0]    rsp_valid,
  output logic [15:0]           rsp_rdata,
  output logic                  rsp_err,
  output logic                  eng_start,
  output logic                  eng_abort,
  output logic [2:0]            eng_cs_sel,
  output logic [31:0]           eng_tx,
  input  logic                  eng_busy,
  input  logic                  eng_done,
  input  logic [15:0]           eng_rx,
  output logic                  sched_busy
);
  localparam int unsigned IW = $clog2(NUM_REQ);
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMO_LOAD = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {ST_IDLE, ST_GRANT, ST_ISSUE, ST_WAIT, ST_RESP} state_t;

  state_t        state_q, state_d;
  logic [IW-1:0] rr_ptr_q, rr_ptr_d;
  logic [IW-1:0] win_q, win_d;
  logic          rw_q, rw_d;
  logic          glob_q, glob_d;
  logic [2:0]    id_q, id_d;
  logic [2:0]    slave_idx_q, slave_idx_d;
  logic [7:0]    addr_q, addr_d;
  logic [15:0]   wdata_q, wdata_d;
  logic [15:0]   rdata_q, rdata_d;
  logic          err_q, err_d;
  logic [31:0]   tx_q, tx_d;
  logic [TW-1:0] tmo_q, tmo_d;

  logic [2:0]    id_arr    [NUM_REQ];
  logic [7:0]    addr_arr  [NUM_REQ];
  logic [15:0]   wdata_arr [NUM_REQ];

  function automatic logic [31:0] frame(input logic rw, input logic [2:0] sid,
                                        input logic [7:0] addr, input logic [15:0] wdata);
    return {rw, sid, addr, 4'b0000, rw ? 16'h0000 : wdata};
  endfunction

  always_comb begin
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      id_arr[i]    = req_id[3*i +: 3];
      addr_arr[i]  = req_addr[8*i +: 8];
      wdata_arr[i] = req_wdata[16*i +: 16];
    end
  end

  always_comb begin
    logic          found;
    logic [IW:0]   sum;
    logic [IW-1:0] idx;
    found       = 1'b0;
    sum         = '0;
    idx         = '0;
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    win_d       = win_q;
    rw_d        = rw_q;
    glob_d      = glob_q;
    id_d        = id_q;
    slave_idx_d = slave_idx_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rdata_d     = rdata_q;
    err_d       = err_q;
    tx_d        = tx_q;
    tmo_d       = tmo_q;
    req_ready   = '0;
    rsp_valid   = '0;
    eng_start   = 1'b0;
    eng_abort   = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        // Scan from rr_ptr with wrap; first pending requester wins.
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
          sum = {1'b0, rr_ptr_q} + (IW+1)'(k);
          if (sum >= (IW+1)'(NUM_REQ)) sum = sum - (IW+1)'(NUM_REQ);
          idx = sum[IW-1:0];
          if (!found && req_valid[idx]) begin
            found   = 1'b1;
            win_d   = idx;
            rw_d    = req_rw[idx];
            glob_d  = req_global[idx];
            id_d    = id_arr[idx];
            addr_d  = addr_arr[idx];
            wdata_d = wdata_arr[idx];
          end
        end
        if (found) state_d = ST_GRANT;
      end
      ST_GRANT: begin
        req_ready[win_q] = 1'b1;
        rr_ptr_d = (win_q == IW'(NUM_REQ - 1)) ? '0 : win_q + 1'b1;
        if (glob_q && rw_q) begin
          err_d   = 1'b1;
          rdata_d = '0;
          state_d = ST_RESP;
        end else begin
          slave_idx_d = glob_q ? 3'd0 : id_q;
          tx_d        = frame(rw_q, glob_q ? 3'd0 : id_q, addr_q, wdata_q);
          state_d     = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (!eng_busy) begin
          eng_start = 1'b1;
          tmo_d     = TMO_LOAD;
          state_d   = ST_WAIT;
        end
      end
      ST_WAIT: begin
        // eng_done is checked first so a completion on the last counted cycle is not aborted.
        if (eng_done) begin
          if (glob_q && (32'(slave_idx_q) < NUM_SLAVES - 1)) begin
            slave_idx_d = slave_idx_q + 3'd1;
            tx_d        = frame(rw_q, slave_idx_q + 3'd1, addr_q, wdata_q);
            state_d     = ST_ISSUE;
          end else begin
            rdata_d = rw_q ? eng_rx : 16'h0000;
            err_d   = 1'b0;
            state_d = ST_RESP;
          end
        end else if (tmo_q == '0) begin
          eng_abort = 1'b1;
          err_d     = 1'b1;
          rdata_d   = '0;
          state_d   = ST_RESP;
        end else begin
          tmo_d = tmo_q - 1'b1;
        end
      end
      ST_RESP: begin
        rsp_valid[win_q] = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      rr_ptr_q    <= '0;
      win_q       <= '0;
      rw_q        <= 1'b0;
      glob_q      <= 1'b0;
      id_q        <= '0;
      slave_idx_q <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rdata_q     <= '0;
      err_q       <= 1'b0;
      tx_q        <= '0;
      tmo_q       <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      win_q       <= win_d;
      rw_q        <= rw_d;
      glob_q      <= glob_d;
      id_q        <= id_d;
      slave_idx_q <= slave_idx_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rdata_q     <= rdata_d;
      err_q       <= err_d;
      tx_q        <= tx_d;
      tmo_q       <= tmo_d;
    end
  end

  assign rsp_rdata  = rdata_q;
  assign rsp_err    = err_q;
  assign eng_cs_sel = slave_idx_q;
  assign eng_tx     = tx_q;
  assign sched_busy = (state_q != ST_IDLE);

endmodule
